// File: rtl/sdram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if
//   Burst command handshake between the port arbiter and the SDRAM command
//   engine.
//
//   cmd_req  : burst request, held until the engine accepts it
//   cmd_wr   : 1 = write burst (drain write FIFO), 0 = read burst
//   cmd_addr : SDRAM word start address {bank, row, col}
//   cmd_len  : burst length in words
//   cmd_ack  : engine accepted the pending request
//   cmd_done : one-cycle pulse, the accepted burst has finished
//
//   master : arbiter side (drives the request fields)
//   slave  : command engine side
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10
);
  logic              cmd_req;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ack;
  logic              cmd_done;

  modport master (
    output cmd_req, cmd_wr, cmd_addr, cmd_len,
    input  cmd_ack, cmd_done
  );

  modport slave (
    input  cmd_req, cmd_wr, cmd_addr, cmd_len,
    output cmd_ack, cmd_done
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//   Burst scheduler for the SDRAM user FIFO ports. It watches the write-FIFO
//   and read-FIFO fill levels and decides when to issue a write burst (drain
//   the write FIFO) or a read burst (refill the read FIFO). Both ports own a
//   burst address that wraps inside [min, max). When both ports want service
//   the grant alternates.
//
//   Ports
//     clk, rst_n          : reference clock, async active-low reset
//     sdram_init_done     : no burst is granted until the SDRAM is ready
//     sdram_read_valid    : read bursts are allowed only while set
//     wr_min/max_addr,
//     wr_len, wr_load     : write region, burst length, address/FIFO reset
//     rd_min/max_addr,
//     rd_len, rd_load     : same for the read port
//     wrf_use, rdf_use    : current FIFO fill levels
//     wrf_clr, rdf_clr    : FIFO clears (loads delayed by one clock)
//     cmd                 : request/ack/done handshake to the command engine
//     busy                : a burst is requested or in progress
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 10,
  parameter int USE_W      = 11,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sdram_init_done,
  input  logic                   sdram_read_valid,
  input  logic [ADDR_W-1:0]      wr_min_addr,
  input  logic [ADDR_W-1:0]      wr_max_addr,
  input  logic [LEN_W-1:0]       wr_len,
  input  logic                   wr_load,
  input  logic [ADDR_W-1:0]      rd_min_addr,
  input  logic [ADDR_W-1:0]      rd_max_addr,
  input  logic [LEN_W-1:0]       rd_len,
  input  logic                   rd_load,
  input  logic [USE_W-1:0]       wrf_use,
  input  logic [USE_W-1:0]       rdf_use,
  output logic                   wrf_clr,
  output logic                   rdf_clr,
  output logic                   busy,
  sdram_port_arbiter_if.master   cmd
);

  // FIFO level comparisons need one extra bit so rdf_use + rd_len cannot wrap.
  localparam int CMP_W = USE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              dir_wr_q, dir_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              last_wr_q, last_wr_d;     // 1 = last accepted grant was a write
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  // A load seen since the port's last grant: the pending done-update of that
  // port must not move its address away from min.
  logic              wr_skip_q, wr_skip_d;
  logic              rd_skip_q, rd_skip_d;

  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;
  logic burst_end;

  // Next burst address: wraps to min when the next burst would start at or
  // beyond max; a degenerate region (min >= max) always restarts at min.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] cur,
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] min_a,
    input logic [ADDR_W-1:0] max_a
  );
    logic [ADDR_W:0] sum;
    sum = {1'b0, cur} + (ADDR_W+1)'(len);
    if ((min_a >= max_a) || (sum >= {1'b0, max_a})) return min_a;
    return sum[ADDR_W-1:0];
  endfunction

  assign wr_elig = sdram_init_done && !wr_load && (wr_len != '0) &&
                   ({1'b0, wrf_use} >= CMP_W'(wr_len));

  assign rd_elig = sdram_init_done && sdram_read_valid && !rd_load && (rd_len != '0) &&
                   (({1'b0, rdf_use} + CMP_W'(rd_len)) <= CMP_W'(FIFO_DEPTH));

  assign burst_end = (state_q == ST_BUSY) && cmd.cmd_done;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    dir_wr_d  = dir_wr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    last_wr_d = last_wr_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // With both ports eligible, serve the one not granted last time.
        if (wr_elig && (!rd_elig || !last_wr_q)) grant_wr = 1'b1;
        else if (rd_elig)                        grant_rd = 1'b1;

        if (grant_wr) begin
          dir_wr_d = 1'b1;
          addr_d   = wr_addr_q;
          len_d    = wr_len;
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end else if (grant_rd) begin
          dir_wr_d = 1'b0;
          addr_d   = rd_addr_q;
          len_d    = rd_len;
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cmd.cmd_ack) begin
          req_d     = 1'b0;
          last_wr_d = dir_wr_q;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cmd.cmd_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Port address update: a live load wins, then the end-of-burst advance
    // for the port that owned the burst (unless a load was seen meanwhile).
    wr_addr_d = wr_addr_q;
    if (wr_load)                                   wr_addr_d = wr_min_addr;
    else if (burst_end && dir_wr_q && !wr_skip_q)  wr_addr_d = next_addr(wr_addr_q, len_q,
                                                                         wr_min_addr, wr_max_addr);

    rd_addr_d = rd_addr_q;
    if (rd_load)                                   rd_addr_d = rd_min_addr;
    else if (burst_end && !dir_wr_q && !rd_skip_q) rd_addr_d = next_addr(rd_addr_q, len_q,
                                                                         rd_min_addr, rd_max_addr);

    // A port can only be granted while its load is low, so the grant is the
    // natural point to forget an earlier load.
    wr_skip_d = wr_skip_q;
    if (wr_load)       wr_skip_d = 1'b1;
    else if (grant_wr) wr_skip_d = 1'b0;

    rd_skip_d = rd_skip_q;
    if (rd_load)       rd_skip_d = 1'b1;
    else if (grant_rd) rd_skip_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      dir_wr_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      last_wr_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_skip_q <= 1'b0;
      rd_skip_q <= 1'b0;
      wrf_clr   <= 1'b1;
      rdf_clr   <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      dir_wr_q  <= dir_wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      last_wr_q <= last_wr_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_skip_q <= wr_skip_d;
      rd_skip_q <= rd_skip_d;
      wrf_clr   <= wr_load;
      rdf_clr   <= rd_load;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign cmd.cmd_req  = req_q;
  assign cmd.cmd_wr   = dir_wr_q;
  assign cmd.cmd_addr = addr_q;
  assign cmd.cmd_len  = len_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//   Directed bench for sdram_port_arbiter. The bench plays the command
//   engine (ack/done) and steps the FIFO levels and load strobes; every
//   expected grant is written out by hand.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int ADDR_W     = 24;
  localparam int LEN_W      = 10;
  localparam int USE_W      = 11;
  localparam int FIFO_DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sdram_init_done;
  logic              sdram_read_valid;
  logic [ADDR_W-1:0] wr_min_addr, wr_max_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_load;
  logic [ADDR_W-1:0] rd_min_addr, rd_max_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_load;
  logic [USE_W-1:0]  wrf_use, rdf_use;
  logic              wrf_clr, rdf_clr, busy;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) cmd_if ();

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .USE_W(USE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sdram_init_done  (sdram_init_done),
    .sdram_read_valid (sdram_read_valid),
    .wr_min_addr      (wr_min_addr),
    .wr_max_addr      (wr_max_addr),
    .wr_len           (wr_len),
    .wr_load          (wr_load),
    .rd_min_addr      (rd_min_addr),
    .rd_max_addr      (rd_max_addr),
    .rd_len           (rd_len),
    .rd_load          (rd_load),
    .wrf_use          (wrf_use),
    .rdf_use          (rdf_use),
    .wrf_clr          (wrf_clr),
    .rdf_clr          (rdf_clr),
    .busy             (busy),
    .cmd              (cmd_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for a request; an expired bound counts as a failed check.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (cmd_if.cmd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, cmd_if.cmd_req, 1'b1);
  endtask

  // Engine model for one burst: check the request, hold it one cycle without
  // ack, accept it, optionally pulse wr_load while busy, then finish it.
  task automatic do_burst(input string tag, input logic exp_wr, input logic [ADDR_W-1:0] exp_addr,
                          input logic [LEN_W-1:0] exp_len, input logic pulse_wr_load);
    wait_req(tag);
    check({tag, "_wr"},   cmd_if.cmd_wr,   exp_wr);
    check({tag, "_addr"}, cmd_if.cmd_addr, exp_addr);
    check({tag, "_len"},  cmd_if.cmd_len,  exp_len);
    tick();
    check({tag, "_hold_req"},  cmd_if.cmd_req,  1'b1);
    check({tag, "_hold_addr"}, cmd_if.cmd_addr, exp_addr);
    cmd_if.cmd_ack = 1'b1;
    tick();
    cmd_if.cmd_ack = 1'b0;
    check({tag, "_ack_req"},  cmd_if.cmd_req, 1'b0);
    check({tag, "_ack_busy"}, busy, 1'b1);
    if (pulse_wr_load) begin
      wr_load = 1'b1;
      tick();
      wr_load = 1'b0;
      check({tag, "_wrf_clr_hi"}, wrf_clr, 1'b1);
      tick();
      check({tag, "_wrf_clr_lo"}, wrf_clr, 1'b0);
    end else begin
      tick();
    end
    cmd_if.cmd_done = 1'b1;
    tick();
    cmd_if.cmd_done = 1'b0;
    check({tag, "_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n            = 1'b0;
    sdram_init_done  = 1'b0;
    sdram_read_valid = 1'b0;
    wr_min_addr      = 24'h000000;
    wr_max_addr      = 24'h400000;
    wr_len           = 10'd256;
    wr_load          = 1'b0;
    rd_min_addr      = 24'h000000;
    rd_max_addr      = 24'h400000;
    rd_len           = 10'd0;
    rd_load          = 1'b0;
    wrf_use          = 11'd300;
    rdf_use          = 11'd0;
    cmd_if.cmd_ack   = 1'b0;
    cmd_if.cmd_done  = 1'b0;

    // Reset values.
    #12;
    check("rst_req",     cmd_if.cmd_req,  1'b0);
    check("rst_wr",      cmd_if.cmd_wr,   1'b0);
    check("rst_addr",    cmd_if.cmd_addr, 24'h0);
    check("rst_len",     cmd_if.cmd_len,  10'h0);
    check("rst_wrf_clr", wrf_clr, 1'b1);
    check("rst_rdf_clr", rdf_clr, 1'b1);
    check("rst_busy",    busy,    1'b0);

    // No grant before init_done, then a one-cycle grant latency.
    tick();
    rst_n = 1'b1;
    ticks(3);
    check("noinit_req", cmd_if.cmd_req, 1'b0);
    check("clr_follow", wrf_clr, 1'b0);
    sdram_init_done = 1'b1;
    tick();
    check("lat_req", cmd_if.cmd_req, 1'b1);

    // Write-only traffic, load pulsed while busy on the 0x200 burst.
    do_burst("w0",   1'b1, 24'h000000, 10'd256, 1'b0);
    do_burst("w1",   1'b1, 24'h000100, 10'd256, 1'b0);
    do_burst("w2",   1'b1, 24'h000200, 10'd256, 1'b1);
    do_burst("wld",  1'b1, 24'h000000, 10'd256, 1'b0);
    wrf_use = 11'd0;

    // Wrap at the top of the write region back to min (0).
    ticks(2);
    wr_min_addr = 24'h3FFE00;
    wr_load     = 1'b1;
    tick();
    wr_load     = 1'b0;
    wr_min_addr = 24'h000000;
    wrf_use     = 11'd300;
    do_burst("wtop0", 1'b1, 24'h3FFE00, 10'd256, 1'b0);
    do_burst("wtop1", 1'b1, 24'h3FFF00, 10'd256, 1'b0);
    do_burst("wwrap", 1'b1, 24'h000000, 10'd256, 1'b0);
    wrf_use = 11'd0;
    ticks(2);

    // Both ports eligible: last grant was a write, so read goes first.
    wrf_use          = 11'd512;
    rdf_use          = 11'd0;
    rd_len           = 10'd256;
    sdram_read_valid = 1'b1;
    do_burst("alt_r0", 1'b0, 24'h000000, 10'd256, 1'b0);
    do_burst("alt_w0", 1'b1, 24'h000100, 10'd256, 1'b0);
    do_burst("alt_r1", 1'b0, 24'h000100, 10'd256, 1'b0);
    do_burst("alt_w1", 1'b1, 24'h000200, 10'd256, 1'b0);
    wrf_use = 11'd0;

    // Read FIFO space boundary: 769 + 256 > 1024, 768 + 256 == 1024.
    rdf_use = 11'd769;
    ticks(4);
    check("rd_full_req", cmd_if.cmd_req, 1'b0);
    rdf_use = 11'd768;
    do_burst("rd_edge", 1'b0, 24'h000200, 10'd256, 1'b0);
    rdf_use          = 11'd0;
    sdram_read_valid = 1'b0;
    ticks(4);
    check("rd_invalid_req", cmd_if.cmd_req, 1'b0);

    // Degenerate read region (min > max): every burst restarts at min.
    sdram_read_valid = 1'b1;
    rd_min_addr      = 24'h001000;
    rd_max_addr      = 24'h000800;
    rd_load          = 1'b1;
    tick();
    rd_load = 1'b0;
    check("rdf_clr_hi", rdf_clr, 1'b1);
    do_burst("deg0", 1'b0, 24'h001000, 10'd256, 1'b0);
    do_burst("deg1", 1'b0, 24'h001000, 10'd256, 1'b0);
    sdram_read_valid = 1'b0;
    ticks(2);

    // Asynchronous reset in the middle of REQ.
    wrf_use = 11'd300;
    wait_req("prerst");
    check("prerst_addr", cmd_if.cmd_addr, 24'h000300);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",     cmd_if.cmd_req,  1'b0);
    check("arst_busy",    busy,            1'b0);
    check("arst_addr",    cmd_if.cmd_addr, 24'h0);
    check("arst_wrf_clr", wrf_clr,         1'b1);
    tick();
    rst_n = 1'b1;
    do_burst("postrst", 1'b1, 24'h000000, 10'd256, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Single-clock scheduler on the controller side of the SDRAM user FIFO ports, in the SDRAM reference-clock domain. It watches write-FIFO and read-FIFO fill levels and decides when to issue a full-page write burst (drain write FIFO) or read burst (refill read FIFO). It hands {direction, address, length} to the SDRAM command engine over a req/ack/done handshake. It owns the wrapping burst address counters between min and max addresses and applies the port load/clear rules.

Parameters:
ADDR_W, 24, SDRAM word address width {bank[1:0], row[12:0], col[8:0]}
LEN_W, 10, burst length width
USE_W, 11, FIFO fill-count width
FIFO_DEPTH, 1024, read FIFO capacity in words

Ports:
clk  in  1  SDRAM controller reference clock (100 MHz); all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sdram_init_done  in  1  no burst is granted while 0
sdram_read_valid  in  1  read bursts are permitted only while 1
wr_min_addr  in  ADDR_W  write region start
wr_max_addr  in  ADDR_W  write region end (exclusive)
wr_len  in  LEN_W  write burst length
wr_load  in  1  level; reset write address, clear write FIFO
rd_min_addr  in  ADDR_W  read region start
rd_max_addr  in  ADDR_W  read region end (exclusive)
rd_len  in  LEN_W  read burst length
rd_load  in  1  level; reset read address, clear read FIFO
wrf_use  in  USE_W  words currently in write FIFO
rdf_use  in  USE_W  words currently in read FIFO
wrf_clr  out  1  write FIFO clear
rdf_clr  out  1  read FIFO clear
cmd_req  out  1  burst request to command engine
cmd_wr  out  1  1 = write burst, 0 = read burst
cmd_addr  out  ADDR_W  burst start address
cmd_len  out  LEN_W  burst length
cmd_ack  in  1  engine accepted request
cmd_done  in  1  one-cycle pulse: burst finished
busy  out  1  high in REQ or BUSY

Behaviour:
- Reset values: cmd_req=0, cmd_wr=0, cmd_addr=0, cmd_len=0, wrf_clr=1, rdf_clr=1, busy=0, wr_addr=0, rd_addr=0, last_grant=read, state=IDLE.
- wrf_clr/rdf_clr are wr_load/rd_load registered by one clk.
- While wr_load=1: wr_addr <= wr_min_addr every cycle and no write grant. rd_load behaves the same for the read port.
- Write eligible: init_done & !wr_load & wr_len!=0 & wrf_use >= wr_len.
- Read eligible: init_done & sdram_read_valid & !rd_load & rd_len!=0 & rdf_use + rd_len <= FIFO_DEPTH, compared in USE_W+1 bits.
- State IDLE:
  - Only one port eligible: grant it.
  - Both eligible: grant the port opposite to last_grant.
  - On grant: latch cmd_wr, cmd_addr (wr_addr or rd_addr) and cmd_len; set cmd_req=1 at the same edge; go to REQ.
  - Latency: eligible at edge N gives cmd_req=1 after edge N.
- State REQ: cmd_req, cmd_wr, cmd_addr and cmd_len are held stable. On cmd_ack=1: cmd_req <= 0, last_grant updated, go to BUSY.
- State BUSY: on cmd_done:
  - Advance the granted port address: next = addr + len, computed in ADDR_W+1 bits.
  - If next >= max, address <= min (wrap); otherwise address <= next.
  - Go to IDLE.
  - IDLE takes at least one cycle before the next grant.
- A load asserted in REQ or BUSY does not abort the burst. The load holds the address at min and the done-update is suppressed for that port.
- cmd_done outside BUSY and cmd_ack outside REQ are ignored.
- min > max or min == max on a port: after each burst the address is forced to min.
- FIFO levels are only sampled in IDLE; changes in REQ/BUSY have no effect until the next arbitration.

Test Plan:
- Reset release, init_done=0, wrf_use=300, wr_len=256 -> cmd_req stays 0. Raise init_done -> cmd_req=1 next cycle, cmd_wr=1, cmd_addr=0, cmd_len=256.
- Write-only traffic, wr_max=0x400000, ack+done per burst -> cmd_addr steps 0x000000, 0x000100 … 0x3FFF00, then wraps to 0x000000.
- Both ports eligible continuously (wrf_use=512, rdf_use=0) -> grants alternate W, R, W, R. Read addresses advance independently: 0, 0x100, …
- rdf_use=769, rd_len=256, FIFO_DEPTH=1024 -> no read grant. rdf_use=768 -> read grant. sdram_read_valid=0 -> no read grant.
- wr_load pulsed during BUSY of write burst at addr 0x000200 -> wrf_clr high one cycle later. After done, next write cmd_addr=wr_min_addr (0), not 0x000300.
- Assert rst_n=0 mid-REQ -> cmd_req, busy=0 immediately (async); addresses 0; state IDLE after release.
